instr_register_alu: RTL and testbench
=====================================

Name: instr_register_alu

Overview:
- Parametrised successor to the 32-entry instruction register.
- Each accepted instruction {opcode, operand_a, operand_b} passes through a 2-stage write pipeline that computes its result, then is stored in a DEPTH-entry register file.
- Two pointer modes: addressed (external pointers) and FIFO (internal pointers, full/empty, sticky overflow and underflow flags).
- Sits between the instruction-generation stimulus and the checker/scoreboard.

Parameters:
- DEPTH, 32, number of entries; power of 2, at least 4.
- OP_W, 32, signed operand width.
- RES_W, 2*OP_W, signed result width.
- ADDR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = ADDRESSED, 1 = FIFO.
- load_en  in  1  write request.
- opcode  in  3  0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD.
- operand_a  in  OP_W  signed.
- operand_b  in  OP_W  signed.
- write_pointer  in  ADDR_W  write address; used only in ADDRESSED mode.
- rd_en  in  1  read request.
- read_pointer  in  ADDR_W  read address; used only in ADDRESSED mode.
- instruction_word  out  3+2*OP_W+RES_W+1  layout MSB to LSB: {opc, op_a, op_b, result, div_err}.
- rd_valid  out  1  instruction_word valid this cycle.
- count  out  ADDR_W+1  committed entries (FIFO mode).
- full  out  1
- empty  out  1
- overflow  out  1  sticky.
- underflow  out  1  sticky.

Behaviour:
- Reset (synchronous, 1 cycle): all entries cleared to 0; internal pointers, count, pipeline valid bits, instruction_word, rd_valid, overflow, underflow all 0; empty = 1, full = 0. Reset mid-operation discards in-flight writes.
- Write pipeline:
  - S0: capture on load_en when accepted.
  - S1: compute result.
  - Commit to memory at end of S1.
  - Write visible to reads launched 2 cycles after the accepting edge.
- Arithmetic (all signed, sign-extended to RES_W):
  - ZERO -> 0; PASSA -> a; PASSB -> b; ADD a+b; SUB a-b; MULT full-width a*b.
  - DIV truncates toward zero; MOD takes the sign of a.
  - b==0 on DIV/MOD -> result 0, div_err = 1; otherwise div_err = 0.
- Read: registered, 1-cycle latency. rd_en at edge N -> instruction_word and rd_valid at N+1. Without rd_en, rd_valid = 0 and instruction_word holds its last value.
- ADDRESSED mode:
  - Write accepted unconditionally at write_pointer; read unconditional at read_pointer.
  - count/full/empty not updated.
  - Read of an address committing in the same cycle returns the old value (see optional feature).
- FIFO mode:
  - Internal wr_ptr/rd_ptr wrap DEPTH-1 -> 0.
  - Write accepted only if count + in-flight writes < DEPTH. Otherwise dropped and overflow set.
  - Read accepted only if count > 0. Otherwise rd_valid = 0 and underflow set.
  - count +1 on commit, -1 on accepted read. Simultaneous commit and read -> count unchanged.
  - full = (count + in-flight == DEPTH); empty = (count == 0). No bypass of in-flight data to an empty FIFO.
- Mode change: clears internal pointers, count, and sticky flags on the next edge; memory retained. Changing mode while writes are in flight is illegal; those writes commit at their addressed/internal target as captured.

Optional Feature:
- INSTR_REG_BYPASS_EN defined: in ADDRESSED mode, a read whose address matches the entry committing this cycle returns the newly committed word. In FIFO mode, a read of an entry committing this cycle is not a case that can occur, so behaviour there is unchanged.
- Undefined: a read always returns pre-commit memory contents.

Test Plan:
- Reset, then ADDRESSED write addr 3 {ADD, a=-7, b=12}; read addr 3 two cycles later -> result 5, div_err 0, rd_valid one cycle after rd_en.
- ADDRESSED: {MULT, a=-2^31, b=-1} -> result +2^31 in 64 bits. {DIV, a=-7, b=2} -> -3. {MOD, a=-7, b=2} -> -1. {DIV, b=0} -> result 0, div_err 1.
- FIFO: 32 back-to-back writes -> full=1 and count=32 once committed; 33rd write dropped, overflow=1; 32 reads return entries in order with wr/rd wrap at 31 -> 0; 33rd read rd_valid=0, underflow=1.
- FIFO at count=32: simultaneous rd_en and load_en -> count stays 32, one entry read, new entry committed.
- Reset asserted in the cycle after a write is accepted -> entry not committed, count=0, all outputs zero.
- ADDRESSED: write addr 9 then read addr 9 in the commit cycle -> old value without INSTR_REG_BYPASS_EN, new value with it.

Source files
------------

// File: rtl/instr_register_alu.sv
// Instruction register file: each accepted {opcode, a, b} is captured, run through a signed ALU and stored in a DEPTH-entry memory.
// Latency: writes commit one edge after acceptance and are seen by reads launched two edges after acceptance; read data follows rd_en by 1 cycle.
// Backpressure: none; in FIFO mode writes beyond capacity are dropped (overflow) and reads of an empty FIFO are refused (underflow).
// Build option: define INSTR_REG_BYPASS_EN to forward a committing word to a same-cycle addressed read of that entry.
module instr_register_alu #(
    parameter  int DEPTH  = 32,
    parameter  int OP_W   = 32,
    parameter  int RES_W  = 2 * OP_W,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int WORD_W = 3 + 2 * OP_W + RES_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              load_en,
    input  logic [2:0]        opcode,
    input  logic [OP_W-1:0]   operand_a,
    input  logic [OP_W-1:0]   operand_b,
    input  logic [ADDR_W-1:0] write_pointer,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] read_pointer,
    output logic [WORD_W-1:0] instruction_word,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic              r_mode;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    // Captured instruction (S0); its result is computed combinationally during S1.
    logic              r_s0_vld;
    logic              r_s0_fifo;
    logic [2:0]        r_s0_opc;
    logic [OP_W-1:0]   r_s0_a;
    logic [OP_W-1:0]   r_s0_b;
    logic [ADDR_W-1:0] r_s0_addr;

    logic                    w_mode_chg;
    logic                    w_fifo_op;
    logic                    w_rd_acc;
    logic                    w_wr_acc;
    logic                    w_bypass;
    logic                    w_div_err;
    logic [ADDR_W+1:0]       w_occ;
    logic [ADDR_W+1:0]       w_occ_after_rd;
    logic [ADDR_W-1:0]       w_rd_addr;
    logic [ADDR_W-1:0]       w_wr_addr;
    logic signed [RES_W-1:0] w_a_ext;
    logic signed [RES_W-1:0] w_b_ext;
    logic signed [RES_W-1:0] w_result;
    logic [WORD_W-1:0]       w_commit_word;
    logic [WORD_W-1:0]       w_rd_word;

    // A mode flip spends its edge clearing FIFO state, so no FIFO operation happens on it.
    assign w_mode_chg     = (mode != r_mode);
    assign w_fifo_op      = mode && !w_mode_chg;
    assign w_occ          = {1'b0, r_count} + {{(ADDR_W+1){1'b0}}, r_s0_vld};
    assign w_rd_acc       = rd_en && (!mode || (w_fifo_op && (r_count != '0)));
    // A read accepted on the same edge frees a slot, so a full FIFO can still take a write.
    assign w_occ_after_rd = w_occ - {{(ADDR_W+1){1'b0}}, w_rd_acc};
    assign w_wr_acc       = load_en && (!mode || (w_fifo_op && (w_occ_after_rd < (ADDR_W+2)'(DEPTH))));
    assign w_rd_addr      = mode ? r_rd_ptr : read_pointer;
    assign w_wr_addr      = mode ? r_wr_ptr : write_pointer;

    assign w_a_ext = {{(RES_W-OP_W){r_s0_a[OP_W-1]}}, r_s0_a};
    assign w_b_ext = {{(RES_W-OP_W){r_s0_b[OP_W-1]}}, r_s0_b};

    // Signed ALU at full result width; divide-by-zero yields 0 and flags div_err.
    always_comb begin
        w_result  = '0;
        w_div_err = 1'b0;
        case (r_s0_opc)
            3'd1: w_result = w_a_ext;
            3'd2: w_result = w_b_ext;
            3'd3: w_result = w_a_ext + w_b_ext;
            3'd4: w_result = w_a_ext - w_b_ext;
            3'd5: w_result = w_a_ext * w_b_ext;
            3'd6: begin
                if (w_b_ext == '0) w_div_err = 1'b1;
                else               w_result  = w_a_ext / w_b_ext;
            end
            3'd7: begin
                if (w_b_ext == '0) w_div_err = 1'b1;
                else               w_result  = w_a_ext % w_b_ext;
            end
            default: w_result = '0;
        endcase
    end

    assign w_commit_word = {r_s0_opc, r_s0_a, r_s0_b, w_result, w_div_err};

`ifdef INSTR_REG_BYPASS_EN
    assign w_bypass = !mode && r_s0_vld && (r_s0_addr == read_pointer);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_rd_word = w_bypass ? w_commit_word : r_mem[w_rd_addr];

    assign count     = r_count;
    assign full      = (w_occ == (ADDR_W+2)'(DEPTH));
    assign empty     = (r_count == '0);
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // Register file: cleared on reset, otherwise takes the S1 word at the end of S1.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (r_s0_vld) begin
            r_mem[r_s0_addr] <= w_commit_word;
        end
    end

    // S0 capture of accepted instructions together with their target entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0_vld  <= 1'b0;
            r_s0_fifo <= 1'b0;
            r_s0_opc  <= '0;
            r_s0_a    <= '0;
            r_s0_b    <= '0;
            r_s0_addr <= '0;
        end else begin
            r_s0_vld <= w_wr_acc;
            if (w_wr_acc) begin
                r_s0_fifo <= mode;
                r_s0_opc  <= opcode;
                r_s0_a    <= operand_a;
                r_s0_b    <= operand_b;
                r_s0_addr <= w_wr_addr;
            end
        end
    end

    // Registered read port; the output word holds when no read is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid         <= 1'b0;
            instruction_word <= '0;
        end else begin
            rd_valid <= w_rd_acc;
            if (w_rd_acc) instruction_word <= w_rd_word;
        end
    end

    // FIFO pointers, occupancy and sticky flags; a mode change wipes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_mode <= mode;
            if (w_mode_chg) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else if (mode) begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + (ADDR_W+1)'(r_s0_vld && r_s0_fifo) - (ADDR_W+1)'(w_rd_acc);
                if (load_en && !w_wr_acc) r_overflow  <= 1'b1;
                if (rd_en && !w_rd_acc)   r_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_register_alu.sv
// Bench for instr_register_alu: scenario tasks with randomized operands checked against a
// plain-arithmetic reference (64-bit integer maths, an address-indexed array and a FIFO queue).
module tb_instr_register_alu;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mode = 1'b0;
    logic         load_en = 1'b0;
    logic [2:0]   opcode = '0;
    logic [31:0]  operand_a = '0;
    logic [31:0]  operand_b = '0;
    logic [4:0]   write_pointer = '0;
    logic         rd_en = 1'b0;
    logic [4:0]   read_pointer = '0;
    logic [131:0] instruction_word;
    logic         rd_valid;
    logic [5:0]   count;
    logic         full;
    logic         empty;
    logic         overflow;
    logic         underflow;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [131:0] mdl_mem [32];
    logic [131:0] fifo_q [$];
    logic [131:0] saved_w;

    always #5 clk = ~clk;

    instr_register_alu dut (
        .clk(clk), .reset(reset), .mode(mode), .load_en(load_en), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .write_pointer(write_pointer),
        .rd_en(rd_en), .read_pointer(read_pointer), .instruction_word(instruction_word),
        .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: expected stored word from the arithmetic rules, using 64-bit integers.
    function automatic logic [131:0] mk_word(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, r;
        logic   e;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        r  = 0;
        e  = 1'b0;
        case (opc)
            3'd1: r = la;
            3'd2: r = lb;
            3'd3: r = la + lb;
            3'd4: r = la - lb;
            3'd5: r = la * lb;
            3'd6: if (lb == 0) e = 1'b1; else r = la / lb;
            3'd7: if (lb == 0) e = 1'b1; else r = la % lb;
            default: r = 0;
        endcase
        return {opc, a, b, r, e};
    endfunction

    function automatic logic [31:0] rnd_op();
        int v;
        if ($urandom_range(0, 2) == 0) begin
            v = int'($urandom_range(0, 8)) - 4;
            return v;
        end
        return $urandom();
    endfunction

    task automatic drive_rand();
        opcode    = 3'($urandom_range(0, 7));
        operand_a = rnd_op();
        operand_b = rnd_op();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
        vec_cnt++;
        if ({instruction_word, rd_valid, count, full, empty, overflow, underflow} !== {132'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset_state: word=%h rd_valid=%b count=%0d full=%b empty=%b ovf=%b unf=%b, want all 0 with empty=1",
                     instruction_word, rd_valid, count, full, empty, overflow, underflow);
        end
    endtask

    task automatic test_addressed_add();
        mode = 1'b0; load_en = 1'b1; write_pointer = 5'd3;
        opcode = 3'd3; operand_a = -7; operand_b = 12;
        tick();
        mdl_mem[3] = mk_word(3'd3, -7, 12);
        load_en = 1'b0;
        tick();
        rd_en = 1'b1; read_pointer = 5'd3;
        vec_cnt++;
        if (rd_valid !== 1'b0) begin err_cnt++; $display("FAIL add_pre_valid: got %b want 0", rd_valid); end
        tick();
        rd_en = 1'b0;
        vec_cnt++;
        if (rd_valid !== 1'b1) begin err_cnt++; $display("FAIL add_rd_valid: got %b want 1", rd_valid); end
        vec_cnt++;
        if (instruction_word[64:0] !== {64'd5, 1'b0}) begin
            err_cnt++; $display("FAIL add_result: got res=%h err=%b want res=5 err=0", instruction_word[64:1], instruction_word[0]);
        end
        vec_cnt++;
        if (instruction_word !== mdl_mem[3]) begin err_cnt++; $display("FAIL add_word: got %h want %h", instruction_word, mdl_mem[3]); end
        tick();
        vec_cnt++;
        if (rd_valid !== 1'b0 || instruction_word !== mdl_mem[3]) begin
            err_cnt++; $display("FAIL add_hold: rd_valid=%b word=%h want 0 and %h", rd_valid, instruction_word, mdl_mem[3]);
        end
    endtask

    task automatic test_arith();
        logic [2:0]  c_opc [5] = '{3'd5, 3'd6, 3'd7, 3'd6, 3'd7};
        logic [31:0] c_a   [5] = '{32'h8000_0000, -7, -7, 123, -5};
        logic [31:0] c_b   [5] = '{32'hFFFF_FFFF, 2, 2, 0, 0};
        logic [64:0] c_exp [5] = '{{64'h0000_0000_8000_0000, 1'b0}, {-64'sd3, 1'b0}, {-64'sd1, 1'b0},
                                   {64'd0, 1'b1}, {64'd0, 1'b1}};
        mode = 1'b0;
        for (int i = 0; i < 21; i++) begin
            load_en = 1'b1;
            write_pointer = 5'(10 + i);
            if (i < 5) begin opcode = c_opc[i]; operand_a = c_a[i]; operand_b = c_b[i]; end
            else drive_rand();
            tick();
            mdl_mem[10 + i] = mk_word(opcode, operand_a, operand_b);
        end
        load_en = 1'b0;
        tick();
        for (int i = 0; i < 21; i++) begin
            rd_en = 1'b1;
            read_pointer = 5'(10 + i);
            tick();
            vec_cnt++;
            if (rd_valid !== 1'b1 || instruction_word !== mdl_mem[10 + i]) begin
                err_cnt++; $display("FAIL arith_word[%0d]: rd_valid=%b got %h want %h", i, rd_valid, instruction_word, mdl_mem[10 + i]);
            end
            if (i < 5) begin
                vec_cnt++;
                if (instruction_word[64:0] !== c_exp[i]) begin
                    err_cnt++; $display("FAIL arith_corner[%0d]: got %h want %h", i, instruction_word[64:0], c_exp[i]);
                end
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_fifo_fill();
        mode = 1'b1;
        tick();
        fifo_q.delete();
        for (int k = 0; k < 32; k++) begin
            load_en = 1'b1;
            drive_rand();
            tick();
            fifo_q.push_back(mk_word(opcode, operand_a, operand_b));
            vec_cnt++;
            if (count !== 6'(k)) begin err_cnt++; $display("FAIL fill_count[%0d]: got %0d want %0d", k, count, k); end
        end
        drive_rand();
        tick();
        load_en = 1'b0;
        vec_cnt++;
        if (count !== 6'd32 || full !== 1'b1 || empty !== 1'b0 || overflow !== 1'b1) begin
            err_cnt++; $display("FAIL fill_full: count=%0d full=%b empty=%b ovf=%b want 32 1 0 1", count, full, empty, overflow);
        end
    endtask

    task automatic test_fifo_full_rw();
        logic [131:0] exp;
        rd_en = 1'b1; load_en = 1'b1;
        drive_rand();
        saved_w = mk_word(opcode, operand_a, operand_b);
        tick();
        exp = fifo_q.pop_front();
        fifo_q.push_back(saved_w);
        rd_en = 1'b0; load_en = 1'b0;
        vec_cnt++;
        if (rd_valid !== 1'b1 || instruction_word !== exp) begin
            err_cnt++; $display("FAIL full_rw_read: rd_valid=%b got %h want %h", rd_valid, instruction_word, exp);
        end
        vec_cnt++;
        if (count !== 6'd31 || full !== 1'b1) begin err_cnt++; $display("FAIL full_rw_mid: count=%0d full=%b want 31 1", count, full); end
        tick();
        vec_cnt++;
        if (count !== 6'd32 || full !== 1'b1) begin err_cnt++; $display("FAIL full_rw_count: count=%0d full=%b want 32 1", count, full); end
    endtask

    task automatic test_fifo_drain();
        logic [131:0] exp;
        exp = '0;
        for (int k = 0; k < 32; k++) begin
            rd_en = 1'b1;
            tick();
            exp = fifo_q.pop_front();
            vec_cnt++;
            if (rd_valid !== 1'b1 || instruction_word !== exp || count !== 6'(31 - k)) begin
                err_cnt++; $display("FAIL drain[%0d]: rd_valid=%b count=%0d got %h want %h count %0d", k, rd_valid, count, instruction_word, exp, 31 - k);
            end
        end
        tick();
        rd_en = 1'b0;
        vec_cnt++;
        if (rd_valid !== 1'b0 || underflow !== 1'b1 || empty !== 1'b1 || instruction_word !== exp) begin
            err_cnt++; $display("FAIL drain_underflow: rd_valid=%b unf=%b empty=%b word=%h want 0 1 1 %h", rd_valid, underflow, empty, instruction_word, exp);
        end
    endtask

    task automatic test_mode_change();
        mode = 1'b0;
        tick();
        vec_cnt++;
        if (overflow !== 1'b0 || underflow !== 1'b0 || count !== 6'd0) begin
            err_cnt++; $display("FAIL mode_clear: ovf=%b unf=%b count=%0d want 0 0 0", overflow, underflow, count);
        end
        rd_en = 1'b1; read_pointer = 5'd0;
        tick();
        rd_en = 1'b0;
        vec_cnt++;
        if (instruction_word !== saved_w) begin err_cnt++; $display("FAIL mode_mem_kept: got %h want %h", instruction_word, saved_w); end
    endtask

    task automatic test_reset_inflight();
        mode = 1'b1;
        tick();
        load_en = 1'b1;
        drive_rand();
        tick();
        load_en = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
        vec_cnt++;
        if ({instruction_word, rd_valid, count, full, empty, overflow, underflow} !== {132'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            err_cnt++; $display("FAIL rst_inflight_out: word=%h rd_valid=%b count=%0d full=%b empty=%b ovf=%b unf=%b",
                                instruction_word, rd_valid, count, full, empty, overflow, underflow);
        end
        tick();
        tick();
        vec_cnt++;
        if (count !== 6'd0 || empty !== 1'b1) begin err_cnt++; $display("FAIL rst_inflight_count: count=%0d empty=%b want 0 1", count, empty); end
        mode = 1'b0;
        tick();
        rd_en = 1'b1; read_pointer = 5'd0;
        tick();
        rd_en = 1'b0;
        vec_cnt++;
        if (rd_valid !== 1'b1 || instruction_word !== mdl_mem[0]) begin
            err_cnt++; $display("FAIL rst_inflight_mem: rd_valid=%b got %h want %h", rd_valid, instruction_word, mdl_mem[0]);
        end
    endtask

    task automatic test_commit_read();
        logic [131:0] v1, v2, exp;
        mode = 1'b0; load_en = 1'b1; write_pointer = 5'd9;
        drive_rand();
        v1 = mk_word(opcode, operand_a, operand_b);
        tick();
        load_en = 1'b0;
        tick();
        load_en = 1'b1;
        drive_rand();
        v2 = mk_word(opcode, operand_a, operand_b);
        tick();
        load_en = 1'b0; rd_en = 1'b1; read_pointer = 5'd9;
        tick();
`ifdef INSTR_REG_BYPASS_EN
        exp = v2;
`else
        exp = v1;
`endif
        vec_cnt++;
        if (rd_valid !== 1'b1 || instruction_word !== exp) begin
            err_cnt++; $display("FAIL commit_cycle_read: rd_valid=%b got %h want %h", rd_valid, instruction_word, exp);
        end
        tick();
        rd_en = 1'b0;
        vec_cnt++;
        if (instruction_word !== v2) begin err_cnt++; $display("FAIL after_commit_read: got %h want %h", instruction_word, v2); end
    endtask

    initial begin
        test_reset();
        test_addressed_add();
        test_arith();
        test_fifo_fill();
        test_fifo_full_rw();
        test_fifo_drain();
        test_mode_change();
        test_reset_inflight();
        test_commit_read();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
